// File: rtl/movegen_pkg.sv
// movegen_pkg: shared types and constants for the move-generation sequencer.
//   mg_state_t  - sequencer FSM states
//   SQ / SQ_W   - square count and square index width
//   sq_idx_t    - square index type
//   PC_*        - piece nibble encodings (colourless), PC_WHITE added for white
package movegen_pkg;

  localparam int unsigned SQ   = 64;
  localparam int unsigned SQ_W = 6;

  typedef logic [SQ_W-1:0] sq_idx_t;

  localparam sq_idx_t SQ_LAST = sq_idx_t'(SQ - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StAttack,
    StScan,
    StDrain,
    StDone
  } mg_state_t;

  localparam logic [3:0] PC_K     = 4'd1;
  localparam logic [3:0] PC_Q     = 4'd2;
  localparam logic [3:0] PC_R     = 4'd3;
  localparam logic [3:0] PC_B     = 4'd4;
  localparam logic [3:0] PC_N     = 4'd5;
  localparam logic [3:0] PC_P     = 4'd6;
  localparam logic [3:0] PC_WHITE = 4'd8;

endpackage

// File: rtl/movegen_sequencer_if.sv
// movegen_sequencer_if: host/array-facing signal bundle of the sequencer.
//   run control : start, wtp_in, ep_file_in, castle_in, busy, done, mv_count
//   board stream: brd_valid, brd_ready, brd_data
//   square array: pos_valid, pos_data, wtp, ep_file, castle_rights,
//                 load_attackers, emit_move, target_square
//   move stream : mv_valid, mv_ready, mv_from, mv_to
// master = host/array side, slave = sequencer side.
interface movegen_sequencer_if;
  import movegen_pkg::*;

  logic          start;
  logic          wtp_in;
  logic [7:0]    ep_file_in;
  logic [3:0]    castle_in;
  logic          brd_valid;
  logic          brd_ready;
  logic [3:0]    brd_data;
  logic          pos_valid;
  logic [3:0]    pos_data;
  logic          wtp;
  logic [7:0]    ep_file;
  logic [3:0]    castle_rights;
  logic          load_attackers;
  logic [SQ-1:0] emit_move;
  logic [SQ-1:0] target_square;
  logic          mv_valid;
  logic          mv_ready;
  sq_idx_t       mv_from;
  sq_idx_t       mv_to;
  logic          busy;
  logic          done;
  logic [7:0]    mv_count;

  modport master (
    output start, wtp_in, ep_file_in, castle_in, brd_valid, brd_data, target_square, mv_ready,
    input  brd_ready, pos_valid, pos_data, wtp, ep_file, castle_rights, load_attackers,
           emit_move, mv_valid, mv_from, mv_to, busy, done, mv_count
  );

  modport slave (
    input  start, wtp_in, ep_file_in, castle_in, brd_valid, brd_data, target_square, mv_ready,
    output brd_ready, pos_valid, pos_data, wtp, ep_file, castle_rights, load_attackers,
           emit_move, mv_valid, mv_from, mv_to, busy, done, mv_count
  );

endinterface

// File: rtl/lsb_index64.sv
// lsb_index64: combinational lowest-set-bit encoder for a 64-bit vector.
//   i_vec  - input vector
//   o_idx  - index of the lowest set bit (0 when i_vec is zero)
//   o_none - high when i_vec is zero
module lsb_index64
  import movegen_pkg::*;
(
  input  logic [SQ-1:0] i_vec,
  output sq_idx_t       o_idx,
  output logic          o_none
);

  always_comb begin
    o_idx  = '0;
    o_none = 1'b1;
    // Descending scan so the last hit wins, leaving the lowest index.
    for (int i = SQ - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx  = sq_idx_t'(i);
        o_none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/movegen_sequencer.sv
// movegen_sequencer: loads a 64-nibble board into the square chain, strobes the
// attacker load, scans every source square and drains each non-empty target
// vector as (from, to) moves over a valid/ready handshake.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - slave view of movegen_sequencer_if (board in, array strobes,
//                move stream out, run status)
module movegen_sequencer
  import movegen_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  movegen_sequencer_if.slave bus
);

  mg_state_t     r_state;
  sq_idx_t       r_sq_cnt;
  sq_idx_t       r_from;
  logic [SQ-1:0] r_tgt;
  logic [7:0]    r_mv_count;
  logic          r_wtp;
  logic [7:0]    r_ep_file;
  logic [3:0]    r_castle;

  sq_idx_t       w_lsb;
  logic          w_none;
  logic [SQ-1:0] w_tgt_rest;
  logic          w_drain;

  lsb_index64 u_lsb (
    .i_vec  (r_tgt),
    .o_idx  (w_lsb),
    .o_none (w_none)
  );

  // Target vector with its lowest bit removed; zero means this is the last move.
  assign w_tgt_rest = r_tgt & (r_tgt - SQ'(1));
  assign w_drain    = (r_state == StDrain);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_sq_cnt   <= '0;
      r_from     <= '0;
      r_tgt      <= '0;
      r_mv_count <= '0;
      r_wtp      <= 1'b0;
      r_ep_file  <= '0;
      r_castle   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_wtp      <= bus.wtp_in;
            r_ep_file  <= bus.ep_file_in;
            r_castle   <= bus.castle_in;
            r_sq_cnt   <= '0;
            r_mv_count <= '0;
            r_state    <= StLoad;
          end
        end
        StLoad: begin
          if (bus.brd_valid) begin
            r_sq_cnt <= r_sq_cnt + sq_idx_t'(1);
            if (r_sq_cnt == SQ_LAST) r_state <= StAttack;
          end
        end
        StAttack: begin
          r_from  <= '0;
          r_state <= StScan;
        end
        StScan: begin
          r_tgt <= bus.target_square;
          if (|bus.target_square) begin
            r_state <= StDrain;
          end else if (r_from == SQ_LAST) begin
            r_state <= StDone;
          end else begin
            r_from <= r_from + sq_idx_t'(1);
          end
        end
        StDrain: begin
          if (bus.mv_ready && !w_none) begin
            r_tgt      <= w_tgt_rest;
            r_mv_count <= r_mv_count + 8'd1;
            if (w_tgt_rest == '0) begin
              if (r_from == SQ_LAST) begin
                r_state <= StDone;
              end else begin
                r_from  <= r_from + sq_idx_t'(1);
                r_state <= StScan;
              end
            end
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.brd_ready      = (r_state == StLoad);
  assign bus.pos_valid      = bus.brd_valid & bus.brd_ready;
  assign bus.pos_data       = bus.brd_data;
  assign bus.wtp            = r_wtp;
  assign bus.ep_file        = r_ep_file;
  assign bus.castle_rights  = r_castle;
  assign bus.load_attackers = (r_state == StAttack);
  assign bus.emit_move      = (r_state == StScan) ? (SQ'(1) << r_from) : '0;
  assign bus.mv_valid       = w_drain & ~w_none;
  assign bus.mv_from        = w_drain ? r_from : '0;
  assign bus.mv_to          = w_drain ? w_lsb : '0;
  assign bus.busy           = (r_state != StIdle);
  assign bus.done           = (r_state == StDone);
  assign bus.mv_count       = r_mv_count;

endmodule

// File: tb/tb_movegen_sequencer.sv
module tb_movegen_sequencer;
  import movegen_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  movegen_sequencer_if bus ();

  movegen_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Board sent by the host, board seen on the chain, and the array model's targets.
  logic [3:0]  board   [64];
  logic [3:0]  chain   [64];
  logic [63:0] tgt_tab [64];

  // Square-array model: targets of whichever source is strobed.
  always_comb begin
    bus.target_square = '0;
    for (int i = 0; i < 64; i++) if (bus.emit_move[i]) bus.target_square |= tgt_tab[i];
  end

  // mode 0: empty or enemy, 1: empty only, 2: enemy only
  function automatic logic [63:0] step(input int r, input int f, input bit white, input int mode);
    logic [3:0] q;
    bit empty, enemy, ok;
    if (r < 0 || r > 7 || f < 0 || f > 7) return '0;
    q     = chain[r*8+f];
    empty = (q == 4'd0);
    enemy = !empty && (q[3] != white);
    ok    = (mode == 0) ? (empty || enemy) : (mode == 1) ? empty : enemy;
    return ok ? (64'd1 << (r*8+f)) : '0;
  endfunction

  // Pseudo-legal targets for K, N and P of the side to move.
  function automatic logic [63:0] gen(input int s, input bit white);
    logic [3:0]  p;
    logic [63:0] t;
    int r, f, d;
    int kr[8] = '{1, 2, 2, 1, -1, -2, -2, -1};
    int kf[8] = '{2, 1, -1, -2, -2, -1, 1, 2};
    p = chain[s];
    t = '0;
    r = s / 8;
    f = s % 8;
    if (p == 4'd0 || p[3] != white) return '0;
    if ({1'b0, p[2:0]} == PC_K) begin
      for (int dr = -1; dr <= 1; dr++)
        for (int df = -1; df <= 1; df++)
          if (dr != 0 || df != 0) t |= step(r + dr, f + df, white, 0);
    end else if ({1'b0, p[2:0]} == PC_N) begin
      for (int k = 0; k < 8; k++) t |= step(r + kr[k], f + kf[k], white, 0);
    end else if ({1'b0, p[2:0]} == PC_P) begin
      d = white ? 1 : -1;
      if (step(r + d, f, white, 1) != 0) begin
        t |= step(r + d, f, white, 1);
        if ((white && r == 1) || (!white && r == 6)) t |= step(r + 2*d, f, white, 1);
      end
      t |= step(r + d, f - 1, white, 2);
      t |= step(r + d, f + 1, white, 2);
    end
    return t;
  endfunction

  task automatic set_board(input int kind);
    logic [3:0] back[8];
    back = '{PC_R, PC_N, PC_B, PC_Q, PC_K, PC_B, PC_N, PC_R};
    for (int i = 0; i < 64; i++) board[i] = 4'd0;
    if (kind == 0) begin
      board[4] = PC_K | PC_WHITE;
    end else if (kind == 1) begin
      for (int i = 0; i < 8; i++) begin
        board[i]      = back[i] | PC_WHITE;
        board[8 + i]  = PC_P | PC_WHITE;
        board[48 + i] = PC_P;
        board[56 + i] = back[i];
      end
    end else begin
      int s;
      for (int c = 0; c < 2; c++) begin
        do s = int'($urandom_range(0, 63)); while (board[s] != 0);
        board[s] = PC_K | (c == 0 ? PC_WHITE : 4'd0);
        for (int k = 0; k < 4; k++) begin
          do s = int'($urandom_range(8, 55)); while (board[s] != 0);
          board[s] = (($urandom_range(0, 1) == 0) ? PC_N : PC_P) | (c == 0 ? PC_WHITE : 4'd0);
        end
      end
    end
  endtask

  typedef struct { int f; int t; } mv_t;
  typedef struct { int n; int ff; int ft; int lf; int lt; int len; } res_t;

  // rdy_mode 0: always ready, 1: toggle, 2: random.
  // stall_mode 0: none, 1: 10-cycle stalls at squares 0/31/63, 2: random.
  task automatic run_case(input string nm, input bit w, input logic [7:0] ep,
                          input logic [3:0] cs, input int rdy_mode, input int stall_mode,
                          input bit poke, input bit stop_drain, output res_t res);
    mv_t  exp_q[$];
    mv_t  m;
    int   ni, stall_left, cyc, first_rdy, done_cyc, npos, nload, ndone, exp_total;
    int   err_order, err_stable, err_emit, err_chain;
    bit   stalled[64];
    bit   hold_valid, poked;
    int   hold_f, hold_t;
    res_t r;
    r = '{0, -1, -1, -1, -1, -1};
    ni = 0; stall_left = 0; first_rdy = -1; done_cyc = -1; npos = 0; nload = 0; ndone = 0;
    exp_total = 0; err_order = 0; err_stable = 0; err_emit = 0; err_chain = 0;
    hold_valid = 0; poked = 0; hold_f = 0; hold_t = 0;
    for (int i = 0; i < 64; i++) stalled[i] = 0;

    @(negedge clk);
    bus.start = 1'b1; bus.wtp_in = w; bus.ep_file_in = ep; bus.castle_in = cs;
    bus.brd_valid = 1'b0; bus.mv_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check({nm, " mv_count clear"}, longint'(bus.mv_count), 0);

    for (cyc = 0; cyc < 3000; cyc++) begin
      bus.start    = 1'b0;
      bus.mv_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      if (ni >= 64) begin
        bus.brd_valid = 1'b0;
      end else if (stall_left > 0) begin
        stall_left--;
        bus.brd_valid = 1'b0;
      end else if (stall_mode == 1 && (ni == 0 || ni == 31 || ni == 63) && !stalled[ni]) begin
        stalled[ni] = 1;
        stall_left = 9;
        bus.brd_valid = 1'b0;
      end else begin
        bus.brd_valid = !(stall_mode == 2 && $urandom_range(0, 3) == 0);
      end
      bus.brd_data = board[ni < 64 ? ni : 63];
      if (poke && !poked && bus.emit_move != 0 && bus.emit_move[0] == 1'b0) begin
        bus.start = 1'b1; bus.wtp_in = ~w; bus.castle_in = ~cs; bus.ep_file_in = ~ep;
        poked = 1;
      end
      #1;
      if (bus.brd_ready && first_rdy < 0) first_rdy = cyc;
      if (bus.pos_valid) begin
        if (npos < 64) chain[npos] = bus.pos_data;
        npos++;
        ni++;
      end
      if (bus.load_attackers) begin
        nload++;
        check({nm, " attack after 64"}, npos, 64);
        for (int s = 0; s < 64; s++) begin
          tgt_tab[s] = gen(s, bus.wtp);
          for (int t = 0; t < 64; t++) if (tgt_tab[s][t]) begin
            exp_q.push_back('{s, t});
            exp_total++;
          end
        end
      end
      if (bus.mv_valid) begin
        if (bus.emit_move != 0) err_emit++;
        if (stop_drain && r.n >= 2) begin
          res = r;
          return;
        end
        if (hold_valid && (int'(bus.mv_from) != hold_f || int'(bus.mv_to) != hold_t)) err_stable++;
        if (bus.mv_ready) begin
          hold_valid = 0;
          if (exp_q.size() == 0) err_order++;
          else begin
            m = exp_q.pop_front();
            if (m.f != int'(bus.mv_from) || m.t != int'(bus.mv_to)) err_order++;
          end
          if (r.n == 0) begin r.ff = int'(bus.mv_from); r.ft = int'(bus.mv_to); end
          r.lf = int'(bus.mv_from); r.lt = int'(bus.mv_to);
          r.n++;
        end else begin
          hold_valid = 1; hold_f = int'(bus.mv_from); hold_t = int'(bus.mv_to);
        end
      end else if (hold_valid) begin
        err_stable++;
        hold_valid = 0;
      end
      if (bus.done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          check({nm, " mv_count"}, longint'(bus.mv_count), exp_total);
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
      @(negedge clk);
    end

    check({nm, " done seen"}, (done_cyc >= 0) ? 1 : 0, 1);
    check({nm, " done pulses"}, ndone, 1);
    check({nm, " pos_valid pulses"}, npos, 64);
    check({nm, " load_attackers"}, nload, 1);
    for (int i = 0; i < 64; i++) if (chain[i] != board[i]) err_chain++;
    check({nm, " chain contents"}, err_chain, 0);
    check({nm, " move order"}, err_order, 0);
    check({nm, " moves left"}, exp_q.size(), 0);
    check({nm, " stall stability"}, err_stable, 0);
    check({nm, " emit in drain"}, err_emit, 0);
    check({nm, " wtp held"}, longint'(bus.wtp), longint'(w));
    check({nm, " castle held"}, longint'(bus.castle_rights), longint'(cs));
    check({nm, " ep held"}, longint'(bus.ep_file), longint'(ep));
    check({nm, " mv_count holds"}, longint'(bus.mv_count), exp_total);
    if (done_cyc >= 0 && first_rdy >= 0) r.len = done_cyc - first_rdy;
    res = r;
  endtask

  typedef struct {
    string      name;
    int         brd;
    bit         w;
    logic [7:0] ep;
    logic [3:0] cs;
    int         rdy;
    int         stall;
    int         n, ff, ft, lf, lt;
  } vec_t;

  vec_t vecs[6];
  res_t res;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) tgt_tab[i] = '0;
    bus.start = 1'b0; bus.wtp_in = 1'b0; bus.ep_file_in = '0; bus.castle_in = '0;
    bus.brd_valid = 1'b0; bus.brd_data = '0; bus.mv_ready = 1'b0;

    // Expected moves: king e1 -> d1,f1,d2,e2,f2; start position knights then pawns.
    vecs[0] = '{"king",        0, 1'b1, 8'h00, 4'h0, 0, 0, 5, 4, 3, 4, 13};
    vecs[1] = '{"startpos",    1, 1'b1, 8'h00, 4'hF, 0, 0, 20, 1, 16, 15, 31};
    vecs[2] = '{"king_bp",     0, 1'b1, 8'h00, 4'h0, 1, 0, 5, 4, 3, 4, 13};
    vecs[3] = '{"king_stall",  0, 1'b1, 8'h10, 4'h3, 0, 1, 5, 4, 3, 4, 13};
    vecs[4] = '{"black_start", 1, 1'b0, 8'h04, 4'hC, 0, 0, 20, 48, 32, 62, 47};
    vecs[5] = '{"start_mixed", 1, 1'b1, 8'h80, 4'h5, 2, 1, 20, 1, 16, 15, 31};

    rst_n = 1'b0;
    #12;
    check("reset busy", longint'(bus.busy), 0);
    check("reset brd_ready", longint'(bus.brd_ready), 0);
    check("reset emit_move", longint'(bus.emit_move), 0);
    check("reset mv_valid", longint'(bus.mv_valid), 0);
    check("reset done", longint'(bus.done), 0);
    check("reset mv_count", longint'(bus.mv_count), 0);
    check("reset wtp", longint'(bus.wtp), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      set_board(vecs[v].brd);
      run_case(vecs[v].name, vecs[v].w, vecs[v].ep, vecs[v].cs, vecs[v].rdy, vecs[v].stall,
               1'b0, 1'b0, res);
      check({vecs[v].name, " count"}, res.n, vecs[v].n);
      check({vecs[v].name, " first from"}, res.ff, vecs[v].ff);
      check({vecs[v].name, " first to"}, res.ft, vecs[v].ft);
      check({vecs[v].name, " last from"}, res.lf, vecs[v].lf);
      check({vecs[v].name, " last to"}, res.lt, vecs[v].lt);
      // Zero stalls: LOAD 64 + ATTACK 1 + SCAN 64 + one cycle per move, then DONE.
      if (vecs[v].rdy == 0 && vecs[v].stall == 0)
        check({vecs[v].name, " run length"}, res.len, 64 + 1 + 64 + vecs[v].n);
    end

    // Reset in the middle of a drain, after two moves have been accepted.
    set_board(1);
    run_case("rst_drain", 1'b1, 8'h00, 4'h1, 0, 0, 1'b0, 1'b1, res);
    check("rst_drain reached", res.n, 2);
    check("pre-reset mv_valid", longint'(bus.mv_valid), 1);
    rst_n = 1'b0;
    #1;
    check("async rst busy", longint'(bus.busy), 0);
    check("async rst mv_valid", longint'(bus.mv_valid), 0);
    check("async rst mv_from", longint'(bus.mv_from), 0);
    check("async rst mv_to", longint'(bus.mv_to), 0);
    check("async rst mv_count", longint'(bus.mv_count), 0);
    check("async rst castle", longint'(bus.castle_rights), 0);
    check("async rst wtp", longint'(bus.wtp), 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_board(0);
    run_case("after_rst", 1'b1, 8'h00, 4'h0, 0, 0, 1'b0, 1'b0, res);
    check("after_rst count", res.n, 5);

    // A start pulse mid-scan with flipped side inputs must have no effect.
    set_board(0);
    run_case("poke", 1'b1, 8'h02, 4'h6, 0, 0, 1'b1, 1'b0, res);
    check("poke count", res.n, 5);
    check("poke busy after", longint'(bus.busy), 0);

    for (int k = 0; k < 3; k++) begin
      set_board(2);
      run_case($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               4'($urandom_range(0, 15)), 2, 2, 1'b0, 1'b0, res);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
